// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq -- instruction sequencer for the 8-bit CPU.
//
// Runs an 8-phase fetch/execute Moore FSM. Every phase advances on each clock
// edge, except the memory fetch phases, which wait for mem_ready. A watchdog
// ends a stall that lasts too long by entering HALTED with fault set. HLT
// also enters HALTED. Only rst leaves HALTED.
//
// Optional feature macro: CPU_CTRL_SINGLE_STEP_EN
//   When it is defined, the module has an extra input, step. The FSM then
//   holds in INST_ADDR until step=1 is sampled, so one instruction runs per
//   step pulse.
//
// Parameters:
//   STALL_LIMIT  stall cycles tolerated in one fetch phase (0 = no watchdog)
//   CNT_W        stall counter width, 2**CNT_W must exceed STALL_LIMIT
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset, also masks all strobes
//   step       in   single-step advance (only with CPU_CTRL_SINGLE_STEP_EN)
//   opcode     in   IR[7:5], sampled when leaving INST_LOAD
//   zero       in   ALU zero flag, used by SKZ in phases 6 and 7
//   mem_ready  in   memory read data valid this cycle
//   alu_op     out  latched opcode sent to the ALU
//   sel        out  address mux select: 1 = PC, 0 = IR operand
//   rd         out  memory read enable
//   ld_ir      out  load instruction register
//   inc_pc     out  increment program counter
//   ld_pc      out  load program counter (jump)
//   ld_ac      out  load accumulator
//   wr         out  memory write
//   data_e     out  accumulator drives the data bus
//   halt       out  CPU halted (sticky until rst)
//   fault      out  stall watchdog expired (sticky until rst, implies halt)
//   phase      out  current phase number, 7 while halted
// -----------------------------------------------------------------------------
module cpu_ctrl_seq #(
   parameter int STALL_LIMIT = 15,
   parameter int CNT_W       = 4
) (
`ifdef CPU_CTRL_SINGLE_STEP_EN
   input  logic       step,
`endif
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] alu_op,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic       fault,
   output logic [2:0] phase
);

   // Opcode encodings
   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   localparam logic [CNT_W-1:0] STALL_LIMIT_C = CNT_W'(STALL_LIMIT);
   localparam bit               WATCHDOG_EN   = (STALL_LIMIT != 0);

   // The low three bits of the phase states are the phase number.
   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8
   } state_t;

   state_t           state_reg, state_next;
   logic [2:0]       alu_op_reg, alu_op_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   logic             fault_reg, fault_next;

   logic is_aluop;   // latched opcode reads memory and updates AC
   logic is_skz, is_jmp, is_sto, is_hlt;
   logic mem_wait;   // current phase waits for mem_ready
   logic go;         // INST_ADDR may advance

   assign is_aluop = (alu_op_reg == OP_ADD) || (alu_op_reg == OP_AND) ||
                     (alu_op_reg == OP_XOR) || (alu_op_reg == OP_LDA);
   assign is_skz   = (alu_op_reg == OP_SKZ);
   assign is_jmp   = (alu_op_reg == OP_JMP);
   assign is_sto   = (alu_op_reg == OP_STO);
   assign is_hlt   = (alu_op_reg == OP_HLT);

   assign mem_wait = (state_reg == INST_FETCH) ||
                     ((state_reg == OP_FETCH) && is_aluop);

`ifdef CPU_CTRL_SINGLE_STEP_EN
   assign go = step;
`else
   assign go = 1'b1;
`endif

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= INST_ADDR;
         alu_op_reg    <= OP_HLT;
         stall_cnt_reg <= '0;
         fault_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         alu_op_reg    <= alu_op_next;
         stall_cnt_reg <= stall_cnt_next;
         fault_reg     <= fault_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      alu_op_next    = alu_op_reg;
      stall_cnt_next = stall_cnt_reg;
      fault_next     = fault_reg;

      case (state_reg)
         INST_ADDR:  if (go) state_next = INST_FETCH;
         INST_FETCH: state_next = INST_LOAD;
         INST_LOAD: begin
            state_next  = IDLE;
            alu_op_next = opcode;
         end
         IDLE:       state_next = OP_ADDR;
         OP_ADDR:    state_next = is_hlt ? HALTED : OP_FETCH;
         OP_FETCH:   state_next = ALU_OP;
         ALU_OP:     state_next = STORE;
         STORE:      state_next = INST_ADDR;
         default:    state_next = HALTED;
      endcase

      // Memory stall overrides the advance. mem_ready=1 wins even when the
      // counter has reached the limit.
      if (mem_wait && !mem_ready) begin
         state_next = state_reg;
         if (WATCHDOG_EN && (stall_cnt_reg == STALL_LIMIT_C)) begin
            state_next = HALTED;
            fault_next = 1'b1;
         end else if (stall_cnt_reg != {CNT_W{1'b1}}) begin
            // Saturates, so it cannot wrap when the watchdog is off.
            stall_cnt_next = stall_cnt_reg + 1'b1;
         end
      end

      if (state_next != state_reg) stall_cnt_next = '0;
   end

   // ---------------------------------------------------------------------
   // Moore strobe decode
   // ---------------------------------------------------------------------
   logic sel_d, rd_d, ld_ir_d, inc_pc_d, ld_pc_d, ld_ac_d, wr_d, data_e_d;

   always_comb begin
      sel_d    = 1'b0;
      rd_d     = 1'b0;
      ld_ir_d  = 1'b0;
      inc_pc_d = 1'b0;
      ld_pc_d  = 1'b0;
      ld_ac_d  = 1'b0;
      wr_d     = 1'b0;
      data_e_d = 1'b0;

      case (state_reg)
         INST_ADDR:  sel_d = 1'b1;
         INST_FETCH: begin
            sel_d = 1'b1;
            rd_d  = 1'b1;
         end
         INST_LOAD, IDLE: begin
            sel_d   = 1'b1;
            rd_d    = 1'b1;
            ld_ir_d = 1'b1;
         end
         OP_ADDR:    inc_pc_d = 1'b1;
         OP_FETCH:   rd_d = is_aluop;
         ALU_OP: begin
            rd_d     = is_aluop;
            inc_pc_d = is_skz && zero;
            ld_pc_d  = is_jmp;
            data_e_d = is_sto;
         end
         STORE: begin
            rd_d     = is_aluop;
            ld_ac_d  = is_aluop;
            inc_pc_d = is_skz && zero;
            ld_pc_d  = is_jmp;
            wr_d     = is_sto;
            data_e_d = is_sto;
         end
         default: ;   // HALTED: everything quiet
      endcase
   end

   // The strobes are masked by rst without a register in between. An
   // asserted reset therefore drops wr at once, and sel stays low until
   // reset is released.
   assign sel    = sel_d    & ~rst;
   assign rd     = rd_d     & ~rst;
   assign ld_ir  = ld_ir_d  & ~rst;
   assign inc_pc = inc_pc_d & ~rst;
   assign ld_pc  = ld_pc_d  & ~rst;
   assign ld_ac  = ld_ac_d  & ~rst;
   assign wr     = wr_d     & ~rst;
   assign data_e = data_e_d & ~rst;

   assign alu_op = alu_op_reg;
   assign halt   = (state_reg == HALTED);
   assign fault  = fault_reg;
   assign phase  = (state_reg == HALTED) ? 3'd7 : state_reg[2:0];

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
module tb_cpu_ctrl_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'b000;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic [2:0] alu_op;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e;
   logic       halt, fault;
   logic [2:0] phase;
   logic [7:0] strb;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   cpu_ctrl_seq dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op), .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc),
      .ld_pc(ld_pc), .ld_ac(ld_ac), .wr(wr), .data_e(data_e),
      .halt(halt), .fault(fault), .phase(phase)
   );

   // strobe vector: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e
   assign strb = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e};

   // Hand-computed expected strobes for phases 0..7 (phase 0 in top byte).
   localparam logic [63:0] EXP_ADD  = 64'h80_C0_E0_E0_10_40_40_44;
   localparam logic [63:0] EXP_STO  = 64'h80_C0_E0_E0_10_00_01_03;
   localparam logic [63:0] EXP_SKZ1 = 64'h80_C0_E0_E0_10_00_10_10;
   localparam logic [63:0] EXP_SKZ0 = 64'h80_C0_E0_E0_10_00_00_00;
   localparam logic [63:0] EXP_JMP  = 64'h80_C0_E0_E0_10_00_08_08;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks one full instruction starting in phase 0.
   task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                            input logic [63:0] exp);
      opcode = op;
      zero   = z;
      for (int p = 0; p < 8; p++) begin
         check($sformatf("%s phase p%0d", name, p), {5'd0, phase}, 8'(p));
         check($sformatf("%s strobes p%0d", name, p), strb, exp[63-8*p -: 8]);
         if (p >= 4)
            check($sformatf("%s alu_op p%0d", name, p), {5'd0, alu_op}, {5'd0, op});
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst strobes", strb, 8'h00);
      check("rst halt/fault/phase", {halt, fault, 3'd0, phase}, 8'h00);
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // ---- reset state ----
      mem_ready = 1'b1;
      tick();
      check("reset strobes", strb, 8'h00);
      check("reset alu_op", {5'd0, alu_op}, 8'h00);
      check("reset halt/fault/phase", {halt, fault, 3'd0, phase}, 8'h00);
      rst = 1'b0;
      #1;
      check("first sel after rst", strb, 8'h80);

      // ---- main instructions, back to back ----
      run_instr("ADD",  3'b010, 1'b0, EXP_ADD);
      run_instr("STO",  3'b110, 1'b0, EXP_STO);
      run_instr("SKZz1", 3'b001, 1'b1, EXP_SKZ1);
      run_instr("SKZz0", 3'b001, 1'b0, EXP_SKZ0);
      run_instr("JMP",  3'b111, 1'b0, EXP_JMP);

      // ---- HLT ----
      opcode = 3'b000;
      for (int p = 0; p < 5; p++) begin
         check($sformatf("HLT strobes p%0d", p), strb, EXP_ADD[63-8*p -: 8]);
         tick();
      end
      check("HLT halt/fault/phase", {halt, fault, 3'd0, phase}, 8'h87);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halted strobes c%0d", i), strb, 8'h00);
         check($sformatf("halted halt c%0d", i), {halt, 4'd0, phase}, 8'h87);
         tick();
      end
      rst = 1'b1;
      #1;
      check("halt cleared by rst", {halt, fault, 3'd0, phase}, 8'h00);
      tick();
      rst = 1'b0;
      #1;

      // ---- stall: 14 low cycles then release ----
      opcode = 3'b010;
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 14; i++) tick();
      check("stall14 hold", {fault, 4'd0, phase}, 8'h01);
      mem_ready = 1'b1;
      tick();
      check("stall14 release", {halt, fault, 3'd0, phase}, 8'h02);

      // ---- stall: 15 low cycles then release on the limit edge ----
      do_reset();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("stall15 hold", {fault, 4'd0, phase}, 8'h01);
      mem_ready = 1'b1;
      tick();
      check("stall15 release", {halt, fault, 3'd0, phase}, 8'h02);

      // ---- stall: watchdog expires ----
      do_reset();
      mem_ready = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("wd pre-fault", {halt, fault, 3'd0, phase}, 8'h01);
      tick();
      check("wd fault", {halt, fault, 3'd0, phase}, 8'hC7);
      check("wd strobes", strb, 8'h00);
      mem_ready = 1'b1;
      tick();
      check("wd sticky", {halt, fault, 3'd0, phase}, 8'hC7);
      do_reset();
      check("wd cleared", {halt, fault, 3'd0, phase}, 8'h00);

      // ---- async reset mid-STORE of STO ----
      opcode = 3'b110;
      for (int p = 0; p < 7; p++) tick();
      check("STO p7 before rst", strb, 8'h03);
      #2;
      rst = 1'b1;
      #1;
      check("async rst wr drop", strb, 8'h00);
      check("async rst phase", {halt, fault, 3'd0, phase}, 8'h00);
      #1;
      rst = 1'b0;
      #1;
      check("post-rst sel", strb, 8'h80);
      run_instr("ADD2", 3'b010, 1'b0, EXP_ADD);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
      $fatal(1, "timeout");
   end

endmodule
